// File: rtl/clkdiv_ctrl.sv
// Run/stop and reconfiguration controller for the LED clock divider.
// Optional burst mode (finite number of CLKOUT periods) enabled by macro CLKDIV_CTRL_BURST_EN.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | divider parked, CLKOUT low, config loads immediately
// ST_RUN      | dividing; config and burst end applied at period boundary
// ST_STOPPING | RUN dropped during high phase; finish it, then idle
module clkdiv_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 7
) (
  input  logic             CLKIN,
  input  logic             RST_L,
  input  logic             RUN,
  input  logic             CFG_REQ,
  input  logic [WIDTH-1:0] CFG_DIV,
  output logic             CFG_ACK,
  input  logic [7:0]       BURST_LEN,
  output logic             CLKOUT,
  output logic             TICK,
  output logic             ACTIVE,
  output logic             DONE
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] cnt;
  logic             cfg_take;
  logic             burst_end;

  // A request still high during its own ACK cycle is the old one, not a new one.
  assign cfg_take = CFG_REQ && !CFG_ACK;
  assign ACTIVE   = (state != ST_IDLE);

`ifdef CLKDIV_CTRL_BURST_EN
  logic [7:0] per_cnt;
  logic [7:0] burst_q;

  assign burst_end = (burst_q != 8'd0) && ((per_cnt + 8'd1) == burst_q);
`else
  logic unused_burst_len;

  assign unused_burst_len = ^BURST_LEN;
  assign burst_end        = 1'b0;
  assign DONE             = 1'b0;
`endif

  always_ff @(posedge CLKIN) begin
    if (!RST_L) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      div_q   <= WIDTH'(DEF_DIV);
      CLKOUT  <= 1'b0;
      TICK    <= 1'b0;
      CFG_ACK <= 1'b0;
`ifdef CLKDIV_CTRL_BURST_EN
      per_cnt <= 8'd0;
      burst_q <= 8'd0;
      DONE    <= 1'b0;
`endif
    end else begin
      TICK    <= 1'b0;
      CFG_ACK <= 1'b0;
`ifdef CLKDIV_CTRL_BURST_EN
      DONE    <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          cnt    <= '0;
          CLKOUT <= 1'b0;
          if (cfg_take) begin
            div_q   <= CFG_DIV;
            CFG_ACK <= 1'b1;
          end
          if (RUN) begin
            state <= ST_RUN;
`ifdef CLKDIV_CTRL_BURST_EN
            per_cnt <= 8'd0;
            burst_q <= BURST_LEN;
`endif
          end
        end
        ST_RUN, ST_STOPPING: begin
          if (state == ST_RUN && !RUN && !CLKOUT) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == div_q) begin
            cnt    <= '0;
            CLKOUT <= ~CLKOUT;
            if (!CLKOUT) begin
              TICK <= 1'b1;
            end else begin
              // High-to-low toggle: period boundary.
`ifdef CLKDIV_CTRL_BURST_EN
              if (per_cnt != 8'hFF) per_cnt <= per_cnt + 8'd1;
`endif
              if (cfg_take) begin
                div_q   <= CFG_DIV;
                CFG_ACK <= 1'b1;
              end
              if (burst_end) begin
                state <= ST_IDLE;
`ifdef CLKDIV_CTRL_BURST_EN
                DONE  <= 1'b1;
`endif
              end else if (state == ST_STOPPING || !RUN) begin
                state <= ST_IDLE;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (state == ST_RUN && !RUN) state <= ST_STOPPING;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed test-plan sequences then random
// stimulus, every cycle compared against a period-position reference model.
module tb_clkdiv_ctrl;

  localparam int WIDTH   = 8;
  localparam int DEF_DIV = 7;

  logic             clk_sys = 1'b0;
  logic             rst_l;
  logic             run;
  logic             cfg_req;
  logic [WIDTH-1:0] cfg_div;
  logic [7:0]       burst_len;
  logic             cfg_ack, clkout, tick, active, done;

  always #5 clk_sys = ~clk_sys;

  clkdiv_ctrl #(.WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) dut (
    .CLKIN     (clk_sys),
    .RST_L     (rst_l),
    .RUN       (run),
    .CFG_REQ   (cfg_req),
    .CFG_DIV   (cfg_div),
    .CFG_ACK   (cfg_ack),
    .BURST_LEN (burst_len),
    .CLKOUT    (clkout),
    .TICK      (tick),
    .ACTIVE    (active),
    .DONE      (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: position within the current full period (age) rather than
  // a half-period counter. CLKOUT is high when age >= half.
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;
  int m_st, m_age, m_div, m_per, m_burst;
  bit m_ack, m_tick, m_done;

  task automatic model_step();
    bit old_ack;
    int half, na;
    old_ack = m_ack;
    m_ack = 0; m_tick = 0; m_done = 0;
    if (!rst_l) begin
      m_st = M_IDLE; m_age = 0; m_div = DEF_DIV; m_per = 0; m_burst = 0;
      return;
    end
    half = m_div + 1;
    if (m_st == M_IDLE) begin
      if (cfg_req && !old_ack) begin m_div = int'(cfg_div); m_ack = 1; end
      if (run) begin m_st = M_RUN; m_age = 0; m_per = 0; m_burst = int'(burst_len); end
    end else begin
      na = m_age + 1;
      if (m_st == M_RUN && !run && na != 2 * half) begin
        if (m_age < half) begin m_st = M_IDLE; m_age = 0; end
        else begin m_st = M_STOP; m_age = na; end
      end else if (na == 2 * half) begin
        m_age = 0;
        m_per++;
        if (cfg_req && !old_ack) begin m_div = int'(cfg_div); m_ack = 1; end
`ifdef CLKDIV_CTRL_BURST_EN
        if (m_burst != 0 && m_per == m_burst) begin m_st = M_IDLE; m_done = 1; end
        else
`endif
        if (m_st == M_STOP || !run) m_st = M_IDLE;
      end else begin
        m_age = na;
        if (na == half) m_tick = 1;
      end
    end
  endtask

  task automatic cycle();
    int exp_clk;
    @(posedge clk_sys);
    model_step();
    #1;
    exp_clk = (m_st != M_IDLE && m_age >= m_div + 1) ? 1 : 0;
    chk("clkout", int'(clkout), exp_clk);
    chk("tick",   int'(tick),   int'(m_tick));
    chk("active", int'(active), (m_st != M_IDLE) ? 1 : 0);
    chk("cfg_ack", int'(cfg_ack), int'(m_ack));
    chk("done",   int'(done),   int'(m_done));
  endtask

  // Requester: keeps CFG_REQ high through the ACK cycle, drops it the cycle after.
  bit drop_pend = 0;

  task automatic req_track();
    if (drop_pend) begin cfg_req = 0; drop_pend = 0; end
    else if (cfg_req && m_ack) drop_pend = 1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      req_track();
    end
  endtask

  task automatic request(input int d);
    cfg_div = WIDTH'(d);
    cfg_req = 1;
  endtask

  task automatic do_reset();
    rst_l = 0; cfg_req = 0; drop_pend = 0;
    cycles(2);
    rst_l = 1;
  endtask

  initial begin
    rst_l = 0; run = 0; cfg_req = 0; cfg_div = '0; burst_len = 8'd0;
    m_st = M_IDLE; m_age = 0; m_div = DEF_DIV; m_per = 0; m_burst = 0;
    m_ack = 0; m_tick = 0; m_done = 0;
    do_reset();

    // Default divide-by-16, continuous.
    run = 1;
    cycles(50);
    // Reconfigure to div 2 while running.
    request(2);
    cycles(40);
    // Drop RUN two cycles into a high phase.
    while (!(m_st == M_RUN && m_age == m_div + 3)) cycles(1);
    run = 0;
    cycles(20);
    // Burst of 3 periods at div 1.
    request(1);
    cycles(4);
    burst_len = 8'd3;
    run = 1;
    cycles(30);
    run = 0;
    cycles(6);
    // Reset mid high phase with a request pending.
    request(5);
    run = 1;
    cycles(3);
    while (!(m_st == M_RUN && m_age == m_div + 2)) cycles(1);
    do_reset();
    cycles(4);
    // Divide-by-2.
    run = 0;
    cycles(3);
    request(0);
    cycles(4);
    burst_len = 8'd0;
    run = 1;
    cycles(20);

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 39) == 0) begin
        run = ~run;
        if (run) burst_len = 8'($urandom_range(0, 4));
      end
      if (!cfg_req && !drop_pend && $urandom_range(0, 19) == 0)
        request($urandom_range(0, 9));
      cycles(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
